// File: rtl/ssd1306_seq.sv
`default_nettype none
// ============================================================================
// Module      : ssd1306_seq
// Description : SSD1306 OLED frame sequencer. After reset it sends the panel
//               init command string. On request it then streams one full
//               frame: an addressing header (commands) followed by FB_BYTES
//               framebuffer bytes (data). The SPI link is mode 0 and sends
//               MSB first. Each byte takes exactly 18*CLK_DIV clocks: 16
//               half-bit periods with ss_o low, then a 2*CLK_DIV gap with
//               ss_o high.
// Parameters  : CLK_DIV  - SCL half-period in clk_i cycles (1..255)
//               FB_BYTES - data bytes per frame
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               frame_req_i           - single-cycle frame request
//               ready_o / busy_o      - init finished / work sent or pending
//               frame_done_o          - one-cycle pulse at end of frame
//               fb_rd_o, fb_addr_o    - framebuffer read strobe and address
//               fb_data_i             - read data, valid one cycle after strobe
//               ss_o, scl_o, mosi_o   - SPI link to the display
//               dc_o                  - 0 = command byte, 1 = data byte
//               invert_i              - only with SSD1306_SEQ_INVERT_EN
// Options     : `define SSD1306_SEQ_INVERT_EN adds invert_i and puts an A6/A7
//               display-invert command in front of the frame header.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd1306_seq #(
    parameter int CLK_DIV  = 4,
    parameter int FB_BYTES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_req_i,
`ifdef SSD1306_SEQ_INVERT_EN
    input  logic       invert_i,
`endif
    output logic       ready_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       fb_rd_o,
    output logic [9:0] fb_addr_o,
    input  logic [7:0] fb_data_i,
    output logic       ss_o,
    output logic       scl_o,
    output logic       mosi_o,
    output logic       dc_o
);

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0]  INIT_LAST = 3'd5;
`ifdef SSD1306_SEQ_INVERT_EN
    localparam logic [2:0]  HDR_LAST  = 3'd6;
`else
    localparam logic [2:0]  HDR_LAST  = 3'd5;
`endif
    localparam logic [7:0]  HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [10:0] DATA_LAST = 11'(FB_BYTES - 1);

    logic [2:0]  state_q, state_d;
    logic        act_q, act_d;       // byte engine running
    logic [7:0]  hcnt_q, hcnt_d;     // clk count inside a half period
    logic [4:0]  slot_q, slot_d;     // 0..15 bit halves, 16..17 gap halves
    logic [2:0]  idx_q, idx_d;       // command index inside INIT/HDR
    logic [10:0] dcnt_q, dcnt_d;     // index of the data byte on the wire
    logic [7:0]  sh_q, sh_d;         // shift register, bit 7 is on mosi
    logic [7:0]  hold_q, hold_d;     // holding latch for the next data byte
    logic        cap_q, cap_d;       // fb_data_i is valid this cycle
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic        dc_q, dc_d;
    logic        fb_rd_q, fb_rd_d;
    logic [9:0]  fb_addr_q, fb_addr_d;
`ifdef SSD1306_SEQ_INVERT_EN
    logic        inv_q, inv_d;
`endif

    logic       half_end, gap_start, byte_end;
    logic       data_last, next_is_data;
    logic [2:0] rom_idx;
    logic [7:0] rom_byte;
    logic [7:0] fb_byte;

    assign half_end  = (hcnt_q == HALF_LAST);
    assign gap_start = act_q && half_end && (slot_q == 5'd15);
    assign byte_end  = act_q && half_end && (slot_q == 5'd17);
    assign data_last = (dcnt_q == DATA_LAST);

    // The next byte is a data byte after the last header byte and after
    // every data byte except the final one.
    assign next_is_data = ((state_q == ST_HDR) && (idx_q == HDR_LAST)) ||
                          ((state_q == ST_DATA) && !data_last);

    // With CLK_DIV=1 the read data arrives in the very cycle the next byte
    // is loaded, so it bypasses the holding latch.
    assign fb_byte = cap_q ? fb_data_i : hold_q;

    // Command to load: entry 0 when the engine starts, else the next one.
    assign rom_idx = act_q ? (idx_q + 3'd1) : 3'd0;

    always_comb begin
        rom_byte = 8'h00;
        if (state_q == ST_INIT) begin
            case (rom_idx)
                3'd0:    rom_byte = 8'hAE;   // display off
                3'd1:    rom_byte = 8'h20;   // addressing mode ...
                3'd2:    rom_byte = 8'h00;   // ... horizontal
                3'd3:    rom_byte = 8'hA4;   // show RAM contents
                3'd4:    rom_byte = 8'hA6;   // normal polarity
                3'd5:    rom_byte = 8'hAF;   // display on
                default: rom_byte = 8'h00;
            endcase
        end else begin
`ifdef SSD1306_SEQ_INVERT_EN
            case (rom_idx)
                3'd0:    rom_byte = inv_q ? 8'hA7 : 8'hA6;
                3'd1:    rom_byte = 8'h21;   // column range 0..127
                3'd2:    rom_byte = 8'h00;
                3'd3:    rom_byte = 8'h7F;
                3'd4:    rom_byte = 8'h22;   // page range 0..7
                3'd5:    rom_byte = 8'h00;
                3'd6:    rom_byte = 8'h07;
                default: rom_byte = 8'h00;
            endcase
`else
            case (rom_idx)
                3'd0:    rom_byte = 8'h21;   // column range 0..127
                3'd1:    rom_byte = 8'h00;
                3'd2:    rom_byte = 8'h7F;
                3'd3:    rom_byte = 8'h22;   // page range 0..7
                3'd4:    rom_byte = 8'h00;
                3'd5:    rom_byte = 8'h07;
                default: rom_byte = 8'h00;
            endcase
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        hcnt_d    = hcnt_q;
        slot_d    = slot_q;
        idx_d     = idx_q;
        dcnt_d    = dcnt_q;
        sh_d      = sh_q;
        hold_d    = hold_q;
        cap_d     = fb_rd_q;
        pend_d    = pend_q | frame_req_i;
        ready_d   = ready_q;
        dc_d      = dc_q;
        fb_rd_d   = 1'b0;
        fb_addr_d = fb_addr_q;
`ifdef SSD1306_SEQ_INVERT_EN
        inv_d     = inv_q;
`endif

        if (cap_q) begin
            hold_d = fb_data_i;
        end

        if (act_q) begin
            if (half_end) begin
                hcnt_d = 8'd0;
                slot_d = slot_q + 5'd1;
                // Advance to the next bit at the end of each SCL-high half.
                if (!slot_q[4] && slot_q[0]) begin
                    sh_d = {sh_q[6:0], 1'b0};
                end
            end else begin
                hcnt_d = hcnt_q + 8'd1;
            end

            // First gap cycle: fetch the upcoming data byte and switch dc
            // while ss is high.
            if (gap_start && next_is_data) begin
                fb_rd_d   = 1'b1;
                fb_addr_d = (state_q == ST_DATA) ? (dcnt_q[9:0] + 10'd1) : 10'd0;
                dc_d      = 1'b1;
            end

            if (byte_end) begin
                slot_d = 5'd0;
                case (state_q)
                    ST_INIT: begin
                        if (idx_q == INIT_LAST) begin
                            state_d = ST_IDLE;
                            act_d   = 1'b0;
                            idx_d   = 3'd0;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                            sh_d  = rom_byte;
                        end
                    end
                    ST_HDR: begin
                        if (idx_q == HDR_LAST) begin
                            state_d = ST_DATA;
                            idx_d   = 3'd0;
                            dcnt_d  = 11'd0;
                            sh_d    = fb_byte;
                        end else begin
                            idx_d = idx_q + 3'd1;
                            sh_d  = rom_byte;
                        end
                    end
                    ST_DATA: begin
                        if (data_last) begin
                            state_d = ST_DONE;
                            act_d   = 1'b0;
                            dcnt_d  = 11'd0;
                        end else begin
                            dcnt_d = dcnt_q + 11'd1;
                            sh_d   = fb_byte;
                        end
                    end
                    default: begin
                        act_d = 1'b0;
                    end
                endcase
            end
        end else begin
            case (state_q)
                ST_INIT, ST_HDR: begin
                    act_d  = 1'b1;
                    hcnt_d = 8'd0;
                    slot_d = 5'd0;
                    idx_d  = 3'd0;
                    sh_d   = rom_byte;
                end
                ST_IDLE: begin
                    // The pending request is consumed when its frame starts.
                    // Requests arriving later, DONE included, set it again
                    // and all merge into one following frame.
                    if (pend_q) begin
                        state_d = ST_HDR;
                        pend_d  = 1'b0;
`ifdef SSD1306_SEQ_INVERT_EN
                        inv_d   = invert_i;
`endif
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    dc_d    = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            act_q     <= 1'b0;
            hcnt_q    <= 8'd0;
            slot_q    <= 5'd0;
            idx_q     <= 3'd0;
            dcnt_q    <= 11'd0;
            sh_q      <= 8'd0;
            hold_q    <= 8'd0;
            cap_q     <= 1'b0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b0;
            dc_q      <= 1'b0;
            fb_rd_q   <= 1'b0;
            fb_addr_q <= 10'd0;
`ifdef SSD1306_SEQ_INVERT_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            hcnt_q    <= hcnt_d;
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            dcnt_q    <= dcnt_d;
            sh_q      <= sh_d;
            hold_q    <= hold_d;
            cap_q     <= cap_d;
            pend_q    <= pend_d;
            ready_q   <= ready_d;
            dc_q      <= dc_d;
            fb_rd_q   <= fb_rd_d;
            fb_addr_q <= fb_addr_d;
`ifdef SSD1306_SEQ_INVERT_EN
            inv_q     <= inv_d;
`endif
        end
    end

    // ss is low for slots 0..15, and SCL is high in the odd slots.
    assign ss_o         = ~(act_q & ~slot_q[4]);
    assign scl_o        = act_q & ~slot_q[4] & slot_q[0];
    assign mosi_o       = act_q & ~slot_q[4] & sh_q[7];
    assign dc_o         = dc_q;
    assign fb_rd_o      = fb_rd_q;
    assign fb_addr_o    = fb_addr_q;
    assign ready_o      = ready_q;
    assign frame_done_o = (state_q == ST_DONE);
    // The reset state is INIT, so busy is masked while reset is applied.
    assign busy_o       = ~rst_i & ((state_q != ST_IDLE) | pend_q);

endmodule
`default_nettype wire

// File: tb/tb_ssd1306_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd1306_seq
// Description : Bench for ssd1306_seq. Instance B (CLK_DIV=4, 8-byte frame)
//               covers init timing and fetch latency at the slow divider.
//               Instance A (CLK_DIV=1, 1024-byte frame) covers the full
//               frame, request merging and reset abort. A single SPI decoder
//               watches the selected instance and checks each byte against
//               an expected-byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd1306_seq;

    localparam int DIV_A = 1;
    localparam int FB_A  = 1024;
    localparam int DIV_B = 4;
    localparam int FB_B  = 8;
`ifdef SSD1306_SEQ_INVERT_EN
    localparam int HDR_N = 7;
`else
    localparam int HDR_N = 6;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, req_a, ready_a, busy_a, done_a, fb_rd_a;
    logic       ss_a, scl_a, mosi_a, dc_a;
    logic [9:0] addr_a;
    logic [7:0] fbd_a;
    logic       rst_b, req_b, ready_b, busy_b, done_b, fb_rd_b;
    logic       ss_b, scl_b, mosi_b, dc_b;
    logic [9:0] addr_b;
    logic [7:0] fbd_b;
`ifdef SSD1306_SEQ_INVERT_EN
    logic       inv_a = 1'b0;
    logic       inv_b = 1'b1;
`endif

    ssd1306_seq #(.CLK_DIV(DIV_A), .FB_BYTES(FB_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .frame_req_i(req_a),
`ifdef SSD1306_SEQ_INVERT_EN
        .invert_i(inv_a),
`endif
        .ready_o(ready_a), .busy_o(busy_a), .frame_done_o(done_a),
        .fb_rd_o(fb_rd_a), .fb_addr_o(addr_a), .fb_data_i(fbd_a),
        .ss_o(ss_a), .scl_o(scl_a), .mosi_o(mosi_a), .dc_o(dc_a)
    );

    ssd1306_seq #(.CLK_DIV(DIV_B), .FB_BYTES(FB_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .frame_req_i(req_b),
`ifdef SSD1306_SEQ_INVERT_EN
        .invert_i(inv_b),
`endif
        .ready_o(ready_b), .busy_o(busy_b), .frame_done_o(done_b),
        .fb_rd_o(fb_rd_b), .fb_addr_o(addr_b), .fb_data_i(fbd_b),
        .ss_o(ss_b), .scl_o(scl_b), .mosi_o(mosi_b), .dc_o(dc_b)
    );

    // Framebuffer model: byte = addr[7:0], valid only the cycle after the
    // strobe, random otherwise.
    always @(posedge clk) fbd_a <= fb_rd_a ? addr_a[7:0] : 8'($urandom);
    always @(posedge clk) fbd_b <= fb_rd_b ? addr_b[7:0] : 8'($urandom);

    logic sel;
    logic m_ss, m_scl, m_mosi, m_dc, m_done, m_busy, m_ready;
    assign m_ss    = sel ? ss_b    : ss_a;
    assign m_scl   = sel ? scl_b   : scl_a;
    assign m_mosi  = sel ? mosi_b  : mosi_a;
    assign m_dc    = sel ? dc_b    : dc_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_ready = sel ? ready_b : ready_a;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    logic [8:0] exp_q[$];

    // ---------------- SPI decoder / scoreboard ----------------
    logic       prev_ss = 1'b1, prev_scl = 1'b0, prev_ready = 1'b0;
    logic       dc_fall, dc_bad, abort_ok;
    logic [7:0] shreg;
    logic [8:0] e;
    int bits = 0, low_cnt = 0, cyc = 0, mon_bytes = 0, n_done = 0, scl_bad = 0;
    int first_fall = -1, ready_cyc = -1;

    initial begin
        dc_fall = 1'b0; dc_bad = 1'b0; shreg = 8'd0; e = 9'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_ss && !m_ss) begin
                bits = 0; shreg = 8'd0; low_cnt = 0; dc_fall = m_dc; dc_bad = 1'b0;
                if (first_fall < 0) first_fall = cyc;
            end
            if (!m_ss) begin
                low_cnt++;
                if (m_dc !== dc_fall) dc_bad = 1'b1;
                if (m_scl && !prev_scl) begin
                    shreg = {shreg[6:0], m_mosi};
                    bits++;
                end
            end else if (m_scl) begin
                scl_bad++;
            end
            if (!prev_ss && m_ss) begin
                if (abort_ok && bits != 8) begin
                    abort_ok = 1'b0;
                end else begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("byte", {dc_bad, dc_fall, shreg}, {1'b0, e});
                        check_eq("byte_timing", bits * 1000 + low_cnt,
                                 8 * 1000 + 16 * (sel ? DIV_B : DIV_A));
                    end
                    mon_bytes++;
                end
            end
            if (m_done) n_done++;
            if (m_ready && !prev_ready) ready_cyc = cyc;
            prev_ss = m_ss; prev_scl = m_scl; prev_ready = m_ready;
        end
    end

    // ---------------- expected-byte helpers ----------------
    task automatic push_init();
        logic [7:0] seq [6] = '{8'hAE, 8'h20, 8'h00, 8'hA4, 8'hA6, 8'hAF};
        foreach (seq[i]) exp_q.push_back({1'b0, seq[i]});
    endtask

    task automatic push_hdr();
        logic [7:0] seq [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
`ifdef SSD1306_SEQ_INVERT_EN
        exp_q.push_back({1'b0, ((sel ? inv_b : inv_a) ? 8'hA7 : 8'hA6)});
`endif
        foreach (seq[i]) exp_q.push_back({1'b0, seq[i]});
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 8'(i)});
    endtask

    task automatic wait_ready(input int div);
        int i = 0;
        while (!m_ready && i < 5000) begin @(negedge clk); i++; end
        @(negedge clk);
        check_eq("ready_latency", ready_cyc - first_fall, 6 * 18 * div);
    endtask

    task automatic wait_done(input int target, input int limit);
        int i = 0;
        while (n_done < target && i < limit) begin @(negedge clk); i++; end
        i = 0;
        while (m_busy && i < 200) begin @(negedge clk); i++; end
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0, b0, i;
        rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
        sel = 1'b1; abort_ok = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("reset_out_b", {ss_b, scl_b, mosi_b, dc_b, fb_rd_b, ready_b,
                                 busy_b, done_b, addr_b}, {8'b1000_0000, 10'd0});
        check_eq("reset_out_a", {ss_a, scl_a, mosi_a, dc_a, fb_rd_a, ready_a,
                                 busy_a, done_a, addr_a}, {8'b1000_0000, 10'd0});

        // Instance B: CLK_DIV=4 init timing and a short frame.
        push_init();
        rst_b = 1'b0;
        wait_ready(DIV_B);
        wait_done(0, 10);
        check_eq("idle_b", {m_ready, m_busy}, 2'b10);
        check_eq("init_drained_b", exp_q.size(), 0);
        d0 = n_done;
        push_hdr(); push_data(FB_B);
        req_b = 1'b1; @(negedge clk); req_b = 1'b0;
        check_eq("busy_after_req_b", m_busy, 1);
        wait_done(d0 + 1, 5000);
        check_eq("frame_done_b", n_done - d0, 1);
        check_eq("sb_drained_b", exp_q.size(), 0);

        // Instance A: CLK_DIV=1, full frame, merged requests, abort.
        rst_b = 1'b1;
        @(negedge clk);
        sel = 1'b0; first_fall = -1; ready_cyc = -1;
        push_init();
        rst_a = 1'b0;
        wait_ready(DIV_A);
        d0 = n_done;
        push_hdr(); push_data(FB_A);
        req_a = 1'b1; @(negedge clk); req_a = 1'b0;
        repeat (3000) @(negedge clk);
        check_eq("busy_mid_frame", m_busy, 1);
        push_hdr(); push_data(FB_A);
        repeat (3) begin
            req_a = 1'b1; @(negedge clk); req_a = 1'b0;
            repeat (400) @(negedge clk);
        end
        wait_done(d0 + 2, 60000);
        b0 = mon_bytes;
        repeat (300) @(negedge clk);
        check_eq("frames_after_merge", n_done - d0, 2);
        check_eq("no_extra_bytes", mon_bytes - b0, 0);
        check_eq("busy_fell", m_busy, 0);
        check_eq("sb_drained_a", exp_q.size(), 0);

        // Reset during data byte 300, bit 5.
        d0 = n_done; b0 = mon_bytes;
        push_hdr(); push_data(300);
        req_a = 1'b1; @(negedge clk); req_a = 1'b0;
        i = 0;
        while (!(mon_bytes == b0 + HDR_N + 300 && bits == 5) && i < 20000) begin
            @(negedge clk); i++;
        end
        check_eq("abort_point", mon_bytes - b0, HDR_N + 300);
        abort_ok = 1'b1; rst_a = 1'b1;
        @(negedge clk);
        check_eq("abort_outputs", {ss_a, scl_a, busy_a, ready_a, done_a}, 5'b10000);
        repeat (20) @(negedge clk);
        check_eq("abort_no_done", n_done - d0, 0);
        check_eq("abort_sb", exp_q.size(), 0);
        first_fall = -1; ready_cyc = -1;
        push_init();
        rst_a = 1'b0;
        wait_ready(DIV_A);
        check_eq("restart_sb", exp_q.size(), 0);
        check_eq("scl_in_gap", scl_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd1306_seq.md
SSD1306_SEQ -- requirements
Module: ssd1306_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SCL half-period in clk_i cycles (legal 1..255).
REQ-002 SHALL have parameter FB_BYTES, default 1024, data bytes per frame (128x64 mono, page-major).
REQ-003 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_req_i  input  1  single-cycle request to push one full frame.
REQ-006 SHALL have port ready_o  output  1  high once the init sequence has completed.
REQ-007 SHALL have port busy_o  output  1  high while any byte is being sent or is pending.
REQ-008 SHALL have port frame_done_o  output  1  one-cycle pulse after the last data byte's gap ends.
REQ-009 SHALL have port fb_rd_o  output  1  framebuffer read strobe, one cycle wide.
REQ-010 SHALL have port fb_addr_o  output  10  framebuffer byte address, {page[2:0], column[6:0]}.
REQ-011 SHALL have port fb_data_i  input  8  framebuffer byte, valid exactly one cycle after fb_rd_o.
REQ-012 SHALL have ports ss_o, scl_o, mosi_o, dc_o  output  1 each  SPI mode-0 link to the display (dc_o 0=command, 1=data).

Function
REQ-013 SHALL implement states INIT, IDLE, HDR, DATA, DONE; after reset the state is INIT.
REQ-014 INIT SHALL send the command bytes AE, 20, 00, A4, A6, AF in that order with dc_o=0, then go to IDLE and set ready_o.
REQ-015 On IDLE with a pending request, the block SHALL go to HDR and send 21, 00, 7F, 22, 00, 07 with dc_o=0.
REQ-016 DATA SHALL send FB_BYTES bytes with dc_o=1, read from fb_addr_o 0..FB_BYTES-1 in ascending order, and then go to DONE.
REQ-017 DONE SHALL last one cycle, assert frame_done_o, clear the pending flag if it was serviced, and return to IDLE.
REQ-018 Each byte SHALL use the following timing:
- ss_o low for 16*CLK_DIV cycles, MSB first.
- Each bit is driven on mosi_o while scl_o is low for CLK_DIV cycles, then scl_o is high for CLK_DIV cycles.
- ss_o is then high with scl_o low for a 2*CLK_DIV-cycle gap.
- A byte occupies exactly 18*CLK_DIV cycles.
REQ-019 dc_o SHALL change only during the gap and SHALL stay stable while ss_o is low.
REQ-020 For each data byte, fb_rd_o SHALL pulse in the first gap cycle of the preceding byte; fb_data_i is captured one cycle later into the shift register's holding latch.
REQ-021 frame_req_i SHALL set a sticky pending flag:
- Requests while busy merge into a single pending frame.
- A request coinciding with DONE is kept and starts the next frame.
REQ-022 frame_req_i received during INIT SHALL be held pending and serviced right after INIT.
REQ-023 busy_o SHALL be high in INIT, HDR, DATA and DONE, and in IDLE whenever a request is pending.
REQ-024 The data byte counter SHALL be 11 bits, and the frame SHALL end exactly at count FB_BYTES with no wrap into a second frame.

Reset
REQ-025 While rst_i is high, the outputs SHALL be: ss_o=1, scl_o=0, mosi_o=0, dc_o=0, fb_rd_o=0, fb_addr_o=0, ready_o=0, busy_o=0, frame_done_o=0.
REQ-026 Reset SHALL clear the pending flag and all counters.
REQ-027 Reset asserted mid-byte or mid-frame SHALL abort immediately: no further SCL edges and no frame_done_o.
REQ-028 After reset is released, the block SHALL restart INIT from the first byte.

Configuration
REQ-029 With macro SSD1306_SEQ_INVERT_EN defined, the block SHALL add port invert_i (input, 1 bit) and sample it at HDR entry.
REQ-030 With SSD1306_SEQ_INVERT_EN defined, HDR SHALL be prefixed by A7 if invert_i=1, else A6, so HDR is 7 bytes.
REQ-031 Without SSD1306_SEQ_INVERT_EN, there SHALL be no invert_i port and HDR SHALL be exactly the 6 bytes of REQ-015.

Verification
REQ-032 Reset release with CLK_DIV=4 -> six bytes AE,20,00,A4,A6,AF decoded with dc=0, each 72 cycles, and ready_o rises 432 cycles after reset release.
REQ-033 frame_req_i pulse with a framebuffer of byte=addr[7:0] -> header 21,00,7F,22,00,07 with dc=0, then 1024 data bytes 00..FF repeated with dc=1, frame_done_o pulses once.
REQ-034 Three frame_req_i pulses during one frame -> exactly one extra frame follows, then busy_o falls.
REQ-035 rst_i asserted at data byte 300, bit 5 -> ss_o=1 next cycle and no frame_done_o; after release AE is the first byte sent.
REQ-036 CLK_DIV=1 -> each byte is 18 cycles, and fb_rd_o-to-capture latency is still 1 cycle with correct data.
REQ-037 SSD1306_SEQ_INVERT_EN defined and invert_i=1 -> header starts A7, then 21,00,7F,22,00,07; with invert_i=0 the header starts A6.
